// File: rtl/mycpu_div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the EXE stage, returning {quotient, remainder}.
// Optional feature: define MYCPU_DIV_EARLY_OUT_EN to bypass CALC when divisor=0 or |dividend| < |divisor|.
module mycpu_div_iter #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    output logic               m_axis_dout_tvalid,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               dz_q, dz_d;
    logic [2*WIDTH-1:0] dout_q, dout_d;

    logic               accept;
    logic               dvd_neg, dsr_neg;
    logic [WIDTH-1:0]   abs_dvd, abs_dsr;
    logic [WIDTH:0]     rem_shift, rem_sub;
    logic               take;

    // Handshake: an operation is taken on an edge where both tvalids and the (shared) tready are high;
    // tready is high only in IDLE, and dout_tvalid is a one-cycle strobe with no back-pressure.
    assign accept = (state_q == IDLE) && s_axis_divisor_tvalid && s_axis_dividend_tvalid;

    assign dvd_neg = SIGNED && s_axis_dividend_tdata[WIDTH-1];
    assign dsr_neg = SIGNED && s_axis_divisor_tdata[WIDTH-1];
    assign abs_dvd = dvd_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
    assign abs_dsr = dsr_neg ? -s_axis_divisor_tdata : s_axis_divisor_tdata;

    // The dividend magnitude is shifted out of quo_q MSB-first while quotient bits shift in at the LSB.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign rem_sub   = rem_shift - {1'b0, dsr_q};
    assign take      = (rem_shift >= {1'b0, dsr_q});

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dsr_d   = abs_dsr;
                    q_neg_d = dvd_neg ^ dsr_neg;
                    r_neg_d = dvd_neg;
                    dz_d    = (s_axis_divisor_tdata == '0);
                    rem_d   = '0;
                    quo_d   = abs_dvd;
                    cnt_d   = '0;
                    state_d = CALC;
`ifdef MYCPU_DIV_EARLY_OUT_EN
                    if ((s_axis_divisor_tdata == '0) || (abs_dvd < abs_dsr)) begin
                        quo_d   = '0;
                        rem_d   = abs_dvd;
                        state_d = FIX;
                    end
`else
`endif
                end
            end
            CALC: begin
                rem_d = take ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], take};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Divide-by-zero reports all-ones regardless of the dividend sign.
                dout_d[2*WIDTH-1:WIDTH] = dz_q ? '1 : (q_neg_q ? -quo_q : quo_q);
                dout_d[WIDTH-1:0]       = r_neg_q ? -rem_q : rem_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            dout_q  <= dout_d;
        end
    end

    assign s_axis_divisor_tready  = (state_q == IDLE);
    assign s_axis_dividend_tready = (state_q == IDLE);
    assign m_axis_dout_tvalid     = (state_q == DONE);
    assign m_axis_dout_tdata      = dout_q;
endmodule

// File: tb/tb_mycpu_div_iter.sv
// Bench for mycpu_div_iter: a signed and an unsigned instance share stimulus and are
// compared against an arithmetic reference model for results and strobe timing.
module tb_mycpu_div_iter;
    logic        clk = 1'b0;
    logic        reset;
    logic        dv_valid, dd_valid;
    logic [31:0] dv_data, dd_data;
    logic        dv_rdy [2];
    logic        dd_rdy [2];
    logic        v      [2];
    logic [63:0] d      [2];

    int          checks   = 0;
    int          failures = 0;

    logic [63:0] res    [2];
    int          lat    [2];
    int          edge2  [2];
    int          nstrb  [2];

    always #5 clk = ~clk;

    mycpu_div_iter #(.WIDTH(32), .SIGNED(1'b1)) dut_s (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_divisor_tvalid  (dv_valid),
        .s_axis_divisor_tready  (dv_rdy[0]),
        .s_axis_divisor_tdata   (dv_data),
        .s_axis_dividend_tvalid (dd_valid),
        .s_axis_dividend_tready (dd_rdy[0]),
        .s_axis_dividend_tdata  (dd_data),
        .m_axis_dout_tvalid     (v[0]),
        .m_axis_dout_tdata      (d[0])
    );

    mycpu_div_iter #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_divisor_tvalid  (dv_valid),
        .s_axis_divisor_tready  (dv_rdy[1]),
        .s_axis_divisor_tdata   (dv_data),
        .s_axis_dividend_tvalid (dd_valid),
        .s_axis_dividend_tready (dd_rdy[1]),
        .s_axis_dividend_tdata  (dd_data),
        .m_axis_dout_tvalid     (v[1]),
        .m_axis_dout_tdata      (d[1])
    );

    // Reference: plain arithmetic, truncating toward zero; index 0 = signed, 1 = unsigned.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input int idx);
        logic [31:0] q, r;
        longint      sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (idx == 1) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
        return {q, r};
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input int idx);
        longint ma, mb;
        ma = longint'(a);
        mb = longint'(b);
        if (idx == 0) begin
            ma = longint'(signed'(a));
            mb = longint'(signed'(b));
            if (ma < 0) ma = -ma;
            if (mb < 0) mb = -mb;
        end
`ifdef MYCPU_DIV_EARLY_OUT_EN
        if (b == 32'd0 || ma < mb) return 2;
`endif
        if (ma < 0 || mb < 0) return 34;
        return 34;
    endfunction

    // Called #1 after the accepting edge (edge 1); records first strobe edge/data and strobe count.
    task automatic observe(input int n);
        for (int i = 0; i < 2; i++) begin
            lat[i] = 0; edge2[i] = 0; nstrb[i] = 0; res[i] = 'x;
        end
        for (int e = 1; e <= n; e++) begin
            for (int i = 0; i < 2; i++) begin
                if (v[i] === 1'b1) begin
                    nstrb[i]++;
                    if (lat[i] == 0) begin
                        lat[i] = e;
                        res[i] = d[i];
                    end else if (edge2[i] == 0) begin
                        edge2[i] = e;
                    end
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic accept_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dd_data = a; dv_data = b; dd_valid = 1'b1; dv_valid = 1'b1;
        @(posedge clk); #1;
        dd_valid = 1'b0; dv_valid = 1'b0;
        dd_data = $urandom; dv_data = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b1; dv_valid = 1'b0; dd_valid = 1'b0; dv_data = '0; dd_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({dv_rdy[i], dd_rdy[i], v[i], d[i]} !== {1'b1, 1'b1, 1'b0, 64'd0}) begin
                failures++;
                $display("FAIL reset_state inst=%0d got rdy=%b%b v=%b d=%h want rdy=11 v=0 d=0",
                         i, dv_rdy[i], dd_rdy[i], v[i], d[i]);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        va = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234, 32'd0, 32'd3, 32'd9, 32'hFFFF_FFF9};
        vb = '{32'hFFFF_FFFE, 32'h10, 32'hFFFF_FFFF, 32'd0, 32'd5, 32'd9, 32'd3, 32'd2};
        for (int k = 0; k < 8; k++) begin
            accept_op(va[k], vb[k]);
            observe(40);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (res[i] !== model(va[k], vb[k], i) || lat[i] != exp_lat(va[k], vb[k], i) || nstrb[i] != 1) begin
                    failures++;
                    $display("FAIL directed k=%0d inst=%0d got d=%h lat=%0d strobes=%0d want d=%h lat=%0d strobes=1",
                             k, i, res[i], lat[i], nstrb[i], model(va[k], vb[k], i), exp_lat(va[k], vb[k], i));
                end
            end
        end
        // Pinned spec values for the signed instance, independent of the model.
        accept_op(32'd7, 32'hFFFF_FFFE);
        observe(40);
        checks++;
        if (res[0] !== 64'hFFFF_FFFD_0000_0001 || lat[0] != 34) begin
            failures++;
            $display("FAIL signed_7_div_m2 got d=%h lat=%0d want d=fffffffd00000001 lat=34", res[0], lat[0]);
        end
        accept_op(32'h8000_0000, 32'hFFFF_FFFF);
        observe(40);
        checks++;
        if (res[0] !== 64'h8000_0000_0000_0000) begin
            failures++;
            $display("FAIL signed_min_div_m1 got d=%h want d=8000000000000000", res[0]);
        end
    endtask

    task automatic test_partial_valid();
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            dv_data = 32'd5; dd_data = 32'd50;
            dv_valid = (pass == 0); dd_valid = (pass == 1);
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (dv_rdy[i] !== 1'b1 || dd_rdy[i] !== 1'b1 || v[i] !== 1'b0) begin
                        failures++;
                        $display("FAIL partial_valid pass=%0d c=%0d inst=%0d got rdy=%b%b v=%b want rdy=11 v=0",
                                 pass, c, i, dv_rdy[i], dd_rdy[i], v[i]);
                    end
                end
            end
            dv_valid = 1'b0; dd_valid = 1'b0;
        end
        observe(40);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (nstrb[i] != 0) begin
                failures++;
                $display("FAIL partial_no_strobe inst=%0d got strobes=%0d want 0", i, nstrb[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        dd_data = 32'd100; dv_data = 32'd7; dd_valid = 1'b1; dv_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            lat[i] = 0; edge2[i] = 0; nstrb[i] = 0; res[i] = 'x;
        end
        for (int e = 1; e <= 70; e++) begin
            for (int i = 0; i < 2; i++) begin
                if (v[i] === 1'b1) begin
                    nstrb[i]++;
                    if (lat[i] == 0) begin
                        lat[i] = e; res[i] = d[i];
                    end else if (edge2[i] == 0) begin
                        edge2[i] = e;
                    end
                end
            end
            if (e == 70) begin
                dd_valid = 1'b0; dv_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (nstrb[i] != 2 || lat[i] != 34 || edge2[i] - lat[i] != 35 || res[i] !== 64'h0000_000E_0000_0002) begin
                failures++;
                $display("FAIL back_to_back inst=%0d got strobes=%0d first=%0d second=%0d d=%h want strobes=2 first=34 second=69 d=0000000e00000002",
                         i, nstrb[i], lat[i], edge2[i], res[i]);
            end
        end
        observe(40);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (nstrb[i] != 0) begin
                failures++;
                $display("FAIL back_to_back_drain inst=%0d got strobes=%0d want 0", i, nstrb[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        accept_op(32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dv_rdy[i] !== 1'b1 || dd_rdy[i] !== 1'b1 || v[i] !== 1'b0) begin
                failures++;
                $display("FAIL abort_ready inst=%0d got rdy=%b%b v=%b want rdy=11 v=0", i, dv_rdy[i], dd_rdy[i], v[i]);
            end
        end
        observe(40);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (nstrb[i] != 0) begin
                failures++;
                $display("FAIL abort_no_strobe inst=%0d got strobes=%0d want 0", i, nstrb[i]);
            end
        end
        accept_op(32'd100, 32'd7);
        observe(40);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (res[i] !== 64'h0000_000E_0000_0002 || lat[i] != 34) begin
                failures++;
                $display("FAIL after_abort inst=%0d got d=%h lat=%0d want d=0000000e00000002 lat=34", i, res[i], lat[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = $urandom_range(1, 20);
                4: a = $urandom_range(0, 50);
                default: ;
            endcase
            accept_op(a, b);
            observe(40);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (res[i] !== model(a, b, i) || lat[i] != exp_lat(a, b, i) || nstrb[i] != 1) begin
                    failures++;
                    $display("FAIL random k=%0d inst=%0d a=%h b=%h got d=%h lat=%0d strobes=%0d want d=%h lat=%0d strobes=1",
                             k, i, a, b, res[i], lat[i], nstrb[i], model(a, b, i), exp_lat(a, b, i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_partial_valid();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
